// File: rtl/l1_mmu_responder_if.sv
// L1 <-> MMU line-fill bus plus the MMU's word port to backing memory.
// Latency: none (wires only).
// Backpressure: memory side uses mem_req held until mem_ack; L1 side holds req_read until done.
interface l1_mmu_responder_if;
  // L1 request / response
  logic         l1_mmu_req_read;
  logic [31:0]  l1_mmu_req_addr;
  logic         mmu_l1_done;
  logic [255:0] mmu_l1_read_data;
  // Backing memory word port
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  // Statistics
  logic [31:0]  fill_count;

  // Responder side (the MMU)
  modport slave (
    input  l1_mmu_req_read, l1_mmu_req_addr, mem_ack, mem_rdata,
    output mmu_l1_done, mmu_l1_read_data, mem_req, mem_addr, fill_count
  );

  // Requester / memory-model side (L1 and backing store)
  modport master (
    output l1_mmu_req_read, l1_mmu_req_addr, mem_ack, mem_rdata,
    input  mmu_l1_done, mmu_l1_read_data, mem_req, mem_addr, fill_count
  );
endinterface

// File: rtl/l1_mmu_responder.sv
// Serves L1 line fills (8 x 32-bit beats) and single-word MMIO reads from a word-wide memory.
// Latency: line = accept + 8 beats + 1 cycles, MMIO = 3 cycles, with mem_ack permanently high.
// Backpressure: mem_req/mem_addr hold until mem_ack; done holds until L1 drops req_read.
module l1_mmu_responder #(
  parameter logic [15:0] MMIO_HI = 16'hFFFF,
  parameter int unsigned BEATS   = 8
) (
  input  logic                sys_clk,
  input  logic                rst,
  l1_mmu_responder_if.slave   bus
);

  // Beat counter is 3 bits wide: the line is always 8 words of 32 bits.
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    MMIO  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    beat_q;
  logic [2:0]    beat_d;
  logic [31:2]   addr_q;        // only word address bits are ever used
  logic [255:0]  line_q;
  logic [31:0]   fill_cnt_q;
  logic [31:0]   mem_addr_d;

  logic          addr_ld;       // latch request address on accept
  logic          beat_wr;       // store mem_rdata into word[beat]
  logic          mmio_wr;       // replace whole line with zero-extended MMIO word
  logic          fill_inc;      // a full line fill just completed

  logic          is_mmio;
  assign is_mmio = (bus.l1_mmu_req_addr[31:16] == MMIO_HI);

  // State and beat counter registers; reset parks the FSM in IDLE.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic and datapath strobes. Dropping req_read mid-transfer
  // wins over a same-cycle ack so a partial line is never completed.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_ld  = 1'b0;
    beat_wr  = 1'b0;
    mmio_wr  = 1'b0;
    fill_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.l1_mmu_req_read) begin
          addr_ld = 1'b1;
          beat_d  = 3'd0;
          state_d = is_mmio ? MMIO : FETCH;
        end
      end
      FETCH: begin
        if (!bus.l1_mmu_req_read) begin
          state_d = DRAIN;
        end else if (bus.mem_ack) begin
          beat_wr = 1'b1;
          beat_d  = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) begin
            fill_inc = 1'b1;
            state_d  = DONE;
          end
        end
      end
      MMIO: begin
        if (!bus.l1_mmu_req_read) begin
          state_d = DRAIN;
        end else if (bus.mem_ack) begin
          mmio_wr = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.l1_mmu_req_read) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address latch, line buffer and fill counter.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      line_q     <= '0;
      fill_cnt_q <= '0;
    end else begin
      if (addr_ld) begin
        addr_q <= bus.l1_mmu_req_addr[31:2];
      end
      if (beat_wr) begin
        line_q[{beat_q, 5'b00000} +: 32] <= bus.mem_rdata;
      end else if (mmio_wr) begin
        line_q <= {224'b0, bus.mem_rdata};
      end
      if (fill_inc) begin
        fill_cnt_q <= fill_cnt_q + 32'd1;
      end
    end
  end

  // Memory address decode from state; zero whenever no request is outstanding.
  always_comb begin
    mem_addr_d = '0;
    case (state_q)
      FETCH:   mem_addr_d = {addr_q[31:5], beat_q, 2'b00};
      MMIO:    mem_addr_d = {addr_q, 2'b00};
      default: mem_addr_d = '0;
    endcase
  end

  // Outputs derive from registered state, so reset clears them immediately.
  assign bus.mem_req          = (state_q == FETCH) || (state_q == MMIO);
  assign bus.mem_addr         = mem_addr_d;
  assign bus.mmu_l1_done      = (state_q == DONE);
  assign bus.mmu_l1_read_data = line_q;
  assign bus.fill_count       = fill_cnt_q;

endmodule

// File: doc/l1_mmu_responder.md
L1_MMU_RESPONDER -- requirements
Module: l1_mmu_responder

Interface
REQ-001 SHALL have parameter MMIO_HI, default 16'hFFFF, meaning a request is MMIO when req_addr[31:16] == MMIO_HI.
REQ-002 SHALL have parameter BEATS, default 8, meaning 32-bit words per 256-bit line (fixed; no other value is supported).
REQ-003 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 l1_mmu_req_read  input  1  read request from L1; held high until done is observed.
REQ-006 l1_mmu_req_addr  input  32  request byte address; bits [4:0] ignored for cached lines.
REQ-007 mmu_l1_done  output  1  response valid; line or MMIO word available.
REQ-008 mmu_l1_read_data  output  256  line data, word k at bits [32k+31:32k]; MMIO word at [31:0].
REQ-009 mem_req  output  1  word read request to the backing memory.
REQ-010 mem_addr  output  32  word-aligned byte address of the current beat.
REQ-011 mem_ack  input  1  backing memory accepted the request; mem_rdata is valid in the same cycle.
REQ-012 mem_rdata  input  32  read word from the backing memory.
REQ-013 fill_count  output  32  count of completed cached line fills.

Function
REQ-014 SHALL implement the FSM states IDLE, FETCH, MMIO, DONE and DRAIN.
REQ-015 In IDLE with req_read=1:
- latch req_addr;
- go to MMIO if the address is MMIO, else go to FETCH with the beat counter at 0.
REQ-016 In FETCH:
- mem_req=1;
- mem_addr = {latched_addr[31:5], beat[2:0], 2'b00};
- on mem_ack, store mem_rdata into word[beat] and increment beat.
REQ-017 The ack of beat 7 SHALL move the FSM to DONE and increment fill_count, wrapping at 2^32.
REQ-018 In MMIO:
- mem_req=1;
- mem_addr = {latched_addr[31:2], 2'b00};
- on mem_ack, set read_data = {224'b0, mem_rdata} and go to DONE.
REQ-019 mem_req SHALL remain high and mem_addr SHALL remain stable until mem_ack; at most one memory request SHALL be outstanding.
REQ-020 mem_req SHALL be 0 in IDLE, DONE and DRAIN.
REQ-021 In DONE:
- mmu_l1_done=1;
- read_data stable;
- stay while req_read=1;
- go to IDLE in the cycle after req_read is sampled 0.
REQ-022 Minimum L1-visible latency SHALL be:
- cached line, mem_ack always 1: 10 cycles from req_read sampled to done (1 accept cycle + 8 beats + 1);
- MMIO, mem_ack always 1: 3 cycles.
REQ-023 If req_read falls during FETCH or MMIO:
- go to DRAIN;
- DRAIN holds mem_req=0 and drops the partial line without asserting done;
- DRAIN returns to IDLE next cycle.
REQ-024 A request is not re-accepted until the FSM is back in IDLE, so a request held across DONE->IDLE SHALL start a new transaction.
REQ-025 read_data SHALL hold its value except when beats are written; a partially filled line SHALL never be presented with done=1.
REQ-026 A cached fill SHALL overwrite all eight words; stale words from a previous MMIO or fill SHALL NOT survive a completed fill.

Reset
REQ-027 When rst=1, the block SHALL immediately (asynchronously) set:
- state = IDLE;
- mmu_l1_done = 0, mem_req = 0, mem_addr = 0;
- mmu_l1_read_data = 0, fill_count = 0;
- beat counter = 0.
REQ-028 Reset asserted mid-FETCH SHALL drop mem_req in the same cycle; after release, the block SHALL wait in IDLE for a fresh req_read.

Verification
REQ-029 Cached fill:
- stimulus: req=1, addr=0x0000_1234, mem_ack always 1, mem returns addr;
- response: mem_addr 0x1220..0x123C in order;
- response: done after 10 cycles;
- response: read_data word k = 0x1220+4k;
- response: fill_count=1.
REQ-030 MMIO read:
- stimulus: addr=0xFFFF_0006, mem_rdata=0xDEADBEEF;
- response: single mem_addr 0xFFFF_0004;
- response: read_data = {224'b0, 32'hDEADBEEF}, done after 3 cycles;
- response: fill_count unchanged.
REQ-031 Backpressure:
- stimulus: mem_ack high only every 3rd cycle;
- response: mem_addr stable while waiting;
- response: exactly 8 acks consumed;
- response: done only after the 8th ack.
REQ-032 Handshake hold:
- stimulus: L1 keeps req=1 for 4 cycles after done;
- response: done and data stay stable;
- response: one cycle after req=0, done=0 and FSM is in IDLE.
REQ-033 Abort and reset:
- stimulus: req drops after beat 3 → response: no done, FSM back in IDLE two cycles later;
- stimulus: separately, rst pulse mid-FETCH → response: mem_req=0 immediately, all outputs 0.
